// File: rtl/result_capture_fifo.sv
// result_capture_fifo: captures valid accumulated words into a FIFO, tracks
// end of burst with a small FSM and raises a level interrupt to the PS.
// Optional macro CAPTURE_LEVEL_EN adds the o_level and o_high_water ports.
module result_capture_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic              i_intr,
  input  logic              i_rd_en,
  input  logic              i_intr_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_intr
`ifdef CAPTURE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [$clog2(DEPTH):0] o_high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              empty_q, full_q;
  logic              overflow_q, overflow_d;
  logic              intr_q;
  logic              rd_acc, wr_acc, drop;

  // Accept/drop decisions and FIFO bookkeeping for this cycle.
  always_comb begin
    rd_acc     = i_rd_en && !empty_q;
    wr_acc     = i_data_valid && (!full_q || rd_acc);
    drop       = i_data_valid && full_q && !rd_acc;
    wr_ptr_d   = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    count_d    = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (i_intr_ack)
      overflow_d = 1'b0;
  end

  // Burst-tracking next-state logic; writes are accepted in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_data_valid) state_d = CAPTURE;
      CAPTURE: if (i_intr && !i_data_valid) state_d = DONE;
      DONE:    if (i_intr_ack) state_d = i_data_valid ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc)
      mem_q[wr_ptr_q] <= i_data;
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(DEPTH));
      overflow_q <= overflow_d;
      intr_q     <= (state_d == DONE);
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_overflow = overflow_q;
  assign o_intr     = intr_q;

`ifdef CAPTURE_LEVEL_EN
  logic [CW-1:0] hw_q, hw_d;

  // High-water mark restarts from the live count on every ack.
  always_comb begin
    hw_d = hw_q;
    if (i_intr_ack)
      hw_d = count_d;
    else if (count_d > hw_q)
      hw_d = count_d;
  end

  // High-water register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      hw_q <= '0;
    else
      hw_q <= hw_d;
  end

  assign o_level      = count_q;
  assign o_high_water = hw_q;
`endif

endmodule

// File: tb/tb_result_capture_fifo.sv
// tb_result_capture_fifo: directed scenarios for result_capture_fifo (DEPTH=4).
module tb_result_capture_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data;
  logic              dataValid;
  logic              upIntr;
  logic              rdEn;
  logic              intrAck;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              intr;
`ifdef CAPTURE_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  logic [$clog2(DEPTH):0] highWater;
`endif

  int total = 0;
  int bad   = 0;

  result_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (dataValid),
    .i_intr       (upIntr),
    .i_rd_en      (rdEn),
    .i_intr_ack   (intrAck),
    .o_rd_data    (rdData),
    .o_rd_valid   (rdValid),
    .o_empty      (empty),
    .o_full       (full),
    .o_overflow   (overflow),
    .o_intr       (intr)
`ifdef CAPTURE_LEVEL_EN
    ,
    .o_level      (level),
    .o_high_water (highWater)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; data = '0; dataValid = 0; upIntr = 0; rdEn = 0; intrAck = 0;
    tick(); tick();
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    total++; if (intr !== 1'b0) begin bad++; $display("[TB] FAIL reset_intr got=%b exp=0", intr); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (rdValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rdvalid got=%b exp=0", rdValid); end
    total++; if (rdData !== 32'd0) begin bad++; $display("[TB] FAIL reset_rddata got=%0d exp=0", rdData); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    logic [31:0] expv [3];
    expv[0] = 32'd3; expv[1] = 32'd5; expv[2] = 32'd9;
    upIntr = 0;
    for (int i = 0; i < 3; i++) begin
      dataValid = 1; data = expv[i]; tick();
    end
    dataValid = 0; upIntr = 1; tick();
    total++; if (intr !== 1'b1) begin bad++; $display("[TB] FAIL burst_intr got=%b exp=1", intr); end
    total++; if (empty !== 1'b0) begin bad++; $display("[TB] FAIL burst_notempty got=%b exp=0", empty); end
    rdEn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rdValid !== 1'b1 || rdData !== expv[i]) begin
        bad++; $display("[TB] FAIL burst_read%0d got=%0d/%b exp=%0d/1", i, rdData, rdValid, expv[i]);
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL burst_empty got=%b exp=1", empty); end
    rdEn = 0; tick();
    total++; if (rdValid !== 1'b0 || rdData !== 32'd9) begin
      bad++; $display("[TB] FAIL burst_hold got=%0d/%b exp=9/0", rdData, rdValid);
    end
    total++; if (intr !== 1'b1) begin bad++; $display("[TB] FAIL burst_intr_held got=%b exp=1", intr); end
    intrAck = 1; tick(); intrAck = 0;
    total++; if (intr !== 1'b0) begin bad++; $display("[TB] FAIL burst_ack got=%b exp=0", intr); end
  endtask

  task automatic test_overflow();
    upIntr = 0;
    for (int i = 1; i <= 6; i++) begin
      dataValid = 1; data = i; tick();
      if (i == 4) begin
        total++; if (full !== 1'b1 || overflow !== 1'b0) begin
          bad++; $display("[TB] FAIL ovf_full4 got=%b/%b exp=1/0", full, overflow);
        end
      end
      if (i == 5) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
      end
    end
    dataValid = 0; upIntr = 1; tick();
    total++; if (intr !== 1'b1 || full !== 1'b1 || overflow !== 1'b1) begin
      bad++; $display("[TB] FAIL ovf_done got=%b/%b/%b exp=1/1/1", intr, full, overflow);
    end
    rdEn = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (rdValid !== 1'b1 || rdData !== 32'(i)) begin
        bad++; $display("[TB] FAIL ovf_read%0d got=%0d/%b exp=%0d/1", i, rdData, rdValid, i);
      end
      if (i == 1) begin
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL ovf_notfull got=%b exp=0", full); end
      end
    end
    rdEn = 0;
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL ovf_empty got=%b exp=1", empty); end
    intrAck = 1; tick(); intrAck = 0;
    total++; if (overflow !== 1'b0 || intr !== 1'b0) begin
      bad++; $display("[TB] FAIL ovf_ack got=%b/%b exp=0/0", overflow, intr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expv [4];
    expv[0] = 32'd11; expv[1] = 32'd12; expv[2] = 32'd13; expv[3] = 32'd7;
    upIntr = 0;
    for (int i = 10; i <= 13; i++) begin
      dataValid = 1; data = i; tick();
    end
    dataValid = 1; data = 32'd7; rdEn = 1; tick();
    total++; if (rdData !== 32'd10 || rdValid !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_pop got=%0d/%b exp=10/1", rdData, rdValid);
    end
    total++; if (full !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_flags got=%b/%b exp=1/0", full, overflow);
    end
    dataValid = 0; upIntr = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (rdValid !== 1'b1 || rdData !== expv[i]) begin
        bad++; $display("[TB] FAIL b2b_read%0d got=%0d/%b exp=%0d/1", i, rdData, rdValid, expv[i]);
      end
    end
    rdEn = 0;
    total++; if (empty !== 1'b1 || intr !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_end got=%b/%b exp=1/1", empty, intr);
    end
    intrAck = 1; tick(); intrAck = 0;
  endtask

  task automatic test_read_empty();
    rdEn = 1; tick(); rdEn = 0;
    total++; if (rdValid !== 1'b0 || rdData !== 32'd7 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL rdempty got=%0d/%b/%b exp=7/0/1", rdData, rdValid, empty);
    end
  endtask

  task automatic test_ack_drop();
    upIntr = 0;
    for (int i = 30; i <= 33; i++) begin
      dataValid = 1; data = i; tick();
    end
    dataValid = 1; data = 32'd99; intrAck = 1; tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ackdrop_ovf got=%b exp=1", overflow); end
    dataValid = 0; intrAck = 1; tick();
    total++; if (overflow !== 1'b0 || intr !== 1'b0) begin
      bad++; $display("[TB] FAIL ack_outside got=%b/%b exp=0/0", overflow, intr);
    end
    intrAck = 0; upIntr = 1; tick();
    total++; if (intr !== 1'b1) begin bad++; $display("[TB] FAIL ackdrop_done got=%b exp=1", intr); end
    rdEn = 1;
    for (int i = 30; i <= 33; i++) begin
      tick();
      total++; if (rdData !== 32'(i)) begin
        bad++; $display("[TB] FAIL ackdrop_read got=%0d exp=%0d", rdData, i);
      end
    end
    rdEn = 0; intrAck = 1; dataValid = 1; data = 32'd20; tick();
    total++; if (intr !== 1'b0 || empty !== 1'b0) begin
      bad++; $display("[TB] FAIL done_recapture got=%b/%b exp=0/0", intr, empty);
    end
    intrAck = 0; dataValid = 0; upIntr = 1; tick();
    total++; if (intr !== 1'b1) begin bad++; $display("[TB] FAIL recapture_done got=%b exp=1", intr); end
    rdEn = 1; tick(); rdEn = 0;
    total++; if (rdData !== 32'd20 || rdValid !== 1'b1) begin
      bad++; $display("[TB] FAIL recapture_read got=%0d/%b exp=20/1", rdData, rdValid);
    end
    intrAck = 1; tick(); intrAck = 0;
    total++; if (intr !== 1'b0) begin bad++; $display("[TB] FAIL recapture_ack got=%b exp=0", intr); end
  endtask

  task automatic test_reset_mid();
    upIntr = 0;
    dataValid = 1; data = 32'd1; tick();
    data = 32'd2; tick();
    total++; if (empty !== 1'b0) begin bad++; $display("[TB] FAIL mid_prefill got=%b exp=0", empty); end
    rst = 1'b0; #1;
    total++; if (empty !== 1'b1 || intr !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset got=%b/%b exp=1/0", empty, intr);
    end
`ifdef CAPTURE_LEVEL_EN
    total++; if (level !== '0 || highWater !== '0) begin
      bad++; $display("[TB] FAIL mid_level got=%0d/%0d exp=0/0", level, highWater);
    end
`endif
    dataValid = 0; upIntr = 1;
    tick(); rst = 1'b1; tick(); tick();
    total++; if (intr !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_after got=%b/%b exp=0/1", intr, empty);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_back_to_back();
    test_read_empty();
    test_ack_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
